// File: rtl/ita_activation_pipe.sv
// Three-stage elastic activation pipe: identity / ReLU / i-GELU per lane, then requantize to WI bits.
// Each stage register loads only when its beat moves forward, so data_o holds while the output is stalled.
module ita_activation_pipe #(
  parameter int N   = 16,
  parameter int WI  = 8,
  parameter int CW  = 16,
  parameter int PW  = 32,
  parameter int EMS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      mode_i,
  input  logic [CW-1:0]   one_i,
  input  logic [CW-1:0]   b_i,
  input  logic [CW-1:0]   c_i,
  input  logic [EMS-1:0]  eps_mult_i,
  input  logic [4:0]      right_shift_i,
  input  logic [WI-1:0]   add_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*WI-1:0] data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [N*WI-1:0] data_o,
  output logic            busy_o
);

  // One guard bit above PW+EMS keeps the rounding increment and offset from wrapping.
  localparam int QW = PW + EMS + 1;
  localparam logic signed [QW-1:0] SAT_HI = QW'(2 ** (WI - 1) - 1);
  localparam logic signed [QW-1:0] SAT_LO = QW'(-(2 ** (WI - 1)));

  logic is_gelu, is_relu, is_ident;
  assign is_gelu  = (mode_i == 2'b10);
  assign is_relu  = (mode_i == 2'b01);
  assign is_ident = ~is_gelu & ~is_relu;

  logic v0_reg, v1_reg, v2_reg;
  logic adv0, adv1, adv2, accept;

  assign adv2        = v2_reg & out_ready_i;
  assign adv1        = v1_reg & (~v2_reg | adv2);
  assign adv0        = v0_reg & (~v1_reg | adv1);
  assign in_ready_o  = ~v0_reg | adv0;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = v2_reg;
  assign busy_o      = v0_reg | v1_reg | v2_reg;

  logic [N*WI-1:0] x0_reg, x1_reg, y2_reg, y2_next;
  logic [N-1:0]    neg0_reg, neg0_next;
  logic [N*PW-1:0] a0_reg, a0_next, g1_reg, g1_next;

  assign data_o = y2_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    // S0: magnitude clipped to -b (signed compare so a positive b clips to a negative bound).
    logic signed [PW-1:0] s0_x, s0_mag, s0_lim;
    always_comb begin
      s0_x   = PW'($signed(data_i[gi*WI +: WI]));
      s0_mag = s0_x[PW-1] ? -s0_x : s0_x;
      s0_lim = -PW'($signed(b_i));
    end
    assign neg0_next[gi]        = s0_x[PW-1];
    assign a0_next[gi*PW +: PW] = (s0_mag < s0_lim) ? s0_mag : s0_lim;

    // S1: L = (a+b)^2 + c, g = x * (sgn*L + one); all arithmetic wraps at PW.
    logic signed [PW-1:0] s1_x, s1_d, s1_poly, s1_sum, s1_g;
    always_comb begin
      s1_x    = PW'($signed(x0_reg[gi*WI +: WI]));
      s1_d    = $signed(a0_reg[gi*PW +: PW]) + PW'($signed(b_i));
      s1_poly = s1_d * s1_d + PW'($signed(c_i));
      s1_sum  = (neg0_reg[gi] ? -s1_poly : s1_poly) + PW'($signed(one_i));
      s1_g    = s1_x;
      if (is_gelu) begin
        s1_g = s1_x * s1_sum;
      end else if (is_relu) begin
        s1_g = neg0_reg[gi] ? '0 : s1_x;
      end
    end
    assign g1_next[gi*PW +: PW] = s1_g;

    // S2: scale, round-half-up on the last shifted-out bit, offset, saturate.
    logic signed [QW-1:0] s2_p, s2_s;
    logic                 s2_rnd;
    logic [WI-1:0]        s2_y;
    always_comb begin
      s2_p   = QW'($signed(g1_reg[gi*PW +: PW])) * QW'($signed({1'b0, eps_mult_i}));
      s2_s   = s2_p >>> right_shift_i;
      s2_rnd = (right_shift_i != 5'd0) && s2_p[right_shift_i - 5'd1];
      if (s2_rnd) begin
        s2_s = s2_s + QW'(1);
      end
      s2_s = s2_s + QW'($signed(add_i));
      if (s2_s > SAT_HI) begin
        s2_y = SAT_HI[WI-1:0];
      end else if (s2_s < SAT_LO) begin
        s2_y = SAT_LO[WI-1:0];
      end else begin
        s2_y = s2_s[WI-1:0];
      end
      if (is_ident) begin
        s2_y = x1_reg[gi*WI +: WI];
      end
    end
    assign y2_next[gi*WI +: WI] = s2_y;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v0_reg   <= 1'b0;
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      x0_reg   <= '0;
      neg0_reg <= '0;
      a0_reg   <= '0;
      x1_reg   <= '0;
      g1_reg   <= '0;
      y2_reg   <= '0;
    end else begin
      v0_reg <= accept | (v0_reg & ~adv0);
      v1_reg <= adv0 | (v1_reg & ~adv1);
      v2_reg <= adv1 | (v2_reg & ~adv2);
      if (accept) begin
        x0_reg   <= data_i;
        neg0_reg <= neg0_next;
        a0_reg   <= a0_next;
      end
      if (adv0) begin
        x1_reg <= x0_reg;
        g1_reg <= g1_next;
      end
      if (adv1) begin
        y2_reg <= y2_next;
      end
    end
  end

endmodule

// File: tb/tb_ita_activation_pipe.sv
// Scoreboard bench for ita_activation_pipe: expected beats are queued on acceptance from an
// integer reference model and popped by a monitor whenever the output handshake fires.
module tb_ita_activation_pipe;
  localparam int N   = 16;
  localparam int WI  = 8;
  localparam int CW  = 16;
  localparam int PW  = 32;
  localparam int EMS = 8;
  localparam int DW  = N * WI;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           mode = 2'b00;
  logic signed [CW-1:0] one = '0;
  logic signed [CW-1:0] b = '0;
  logic signed [CW-1:0] c = '0;
  logic [EMS-1:0]       eps = 8'd1;
  logic [4:0]           sh = 5'd0;
  logic signed [WI-1:0] add = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DW-1:0]        data_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        data_o;
  logic                 busy;

  ita_activation_pipe #(.N(N), .WI(WI), .CW(CW), .PW(PW), .EMS(EMS)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .one_i(one), .b_i(b), .c_i(c),
    .eps_mult_i(eps), .right_shift_i(sh), .add_i(add),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .data_i(data_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(data_o), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            timed;
  } exp_t;

  exp_t          q[$];
  int            n_chk = 0, n_pass = 0;
  int            occ = 0, cyc = 0, stall_seen = 0, n_pop = 0;
  bit            timed = 1'b0, prev_stall = 1'b0, done = 1'b0;
  logic [DW-1:0] prev_data = '0, last_out = '0;

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, expv);
  endtask

  // Reference: plain integer arithmetic (int wraps at 32 bits = PW).
  function automatic logic [WI-1:0] model_lane(input logic [WI-1:0] xv);
    int     x, g, a, lim, d, poly, sgn;
    longint p, s;
    x = int'($signed(xv));
    if (mode == 2'b00 || mode == 2'b11) return xv;
    if (mode == 2'b01) begin
      g = (x < 0) ? 0 : x;
    end else begin
      sgn = (x < 0) ? -1 : 1;
      a   = (x < 0) ? -x : x;
      lim = -int'(b);
      if (lim < a) a = lim;
      d    = a + int'(b);
      poly = d * d + int'(c);
      g    = x * (sgn * poly + int'(one));
    end
    p = longint'(g) * longint'(eps);
    s = p >>> sh;
    if (sh != 5'd0 && p[sh - 5'd1]) s = s + 1;
    s = s + longint'(add);
    if (s > longint'(2 ** (WI - 1) - 1)) s = longint'(2 ** (WI - 1) - 1);
    else if (s < -longint'(2 ** (WI - 1))) s = -longint'(2 ** (WI - 1));
    return WI'(s);
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*WI +: WI] = model_lane(d[k*WI +: WI]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*WI +: WI] = WI'($urandom);
    return r;
  endfunction

  // Monitor: all bookkeeping sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        occ = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", DW'(out_valid), DW'(1'b1));
        chk("hold_data", data_o, prev_data);
      end
      chk("in_ready", DW'(in_ready), DW'((occ < 3) || out_ready));
      chk("busy", DW'(busy), DW'(occ != 0));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_out: got beat %h, expected no output (queue empty)", data_o);
        end else begin
          e = q.pop_front();
          chk("data", data_o, e.data);
          if (e.timed) chk("latency", DW'(cyc - e.cyc), DW'(3));
          $display("beat %0d out=%h", n_pop, data_o);
          last_out = data_o;
          n_pop++;
          occ--;
        end
      end
      if (in_valid && !in_ready) stall_seen++;
      if (in_valid && in_ready) begin
        q.push_back('{model_beat(data_in), cyc, timed});
        occ++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = data_o;
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit t);
    int w = 0;
    timed = t;
    data_in = d;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 300);
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    timed = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy || q.size() != 0) && w < 300);
    if (busy || q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: busy=%0b pending=%0d, expected 0/0", busy, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic signed [CW-1:0] o,
                         input logic signed [CW-1:0] bb, input logic signed [CW-1:0] cc,
                         input logic [EMS-1:0] e, input logic [4:0] s,
                         input logic signed [WI-1:0] a);
    wait_idle();
    mode = m; one = o; b = bb; c = cc; eps = e; sh = s; add = a;
  endtask

  initial begin
    logic [DW-1:0] d;
    int            base_stall, base_pop;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", DW'(out_valid), DW'(1'b0));
    chk("reset_data_o", data_o, '0);
    chk("reset_busy", DW'(busy), DW'(1'b0));
    chk("reset_in_ready", DW'(in_ready), DW'(1'b1));
    @(posedge clk);
    #1;

    // Identity, x=-7, 3-cycle latency
    set_cfg(2'b00, 16'sd0, 16'sd0, 16'sd0, 8'd1, 5'd0, 8'sd0);
    d = rand_beat();
    d[WI-1:0] = 8'hF9;
    send(d, 1'b1);
    wait_idle();
    chk("ident_x_m7", DW'(last_out[WI-1:0]), DW'(8'hF9));

    // ReLU {5,-5}, eps=3, shift=1 -> {8,0}
    set_cfg(2'b01, 16'sd0, 16'sd0, 16'sd0, 8'd3, 5'd1, 8'sd0);
    d = rand_beat();
    d[0 +: WI] = 8'd5;
    d[WI +: WI] = 8'hFB;
    send(d, 1'b1);
    wait_idle();
    chk("relu_5", DW'(last_out[0 +: WI]), DW'(8'd8));
    chk("relu_m5", DW'(last_out[WI +: WI]), DW'(8'd0));

    // GELU one=10 b=-4 c=1
    set_cfg(2'b10, 16'sd10, -16'sd4, 16'sd1, 8'd1, 5'd0, 8'sd0);
    d = rand_beat();
    d[0 +: WI] = 8'd2;
    d[WI +: WI] = 8'hFD;
    d[2*WI +: WI] = 8'h9C;
    d[3*WI +: WI] = 8'h64;
    send(d, 1'b1);
    wait_idle();
    chk("gelu_2", DW'(last_out[0 +: WI]), DW'(8'd30));
    chk("gelu_m3", DW'(last_out[WI +: WI]), DW'(8'hE8));
    chk("gelu_m100_sat", DW'(last_out[2*WI +: WI]), DW'(8'h80));
    chk("gelu_100_sat", DW'(last_out[3*WI +: WI]), DW'(8'h7F));

    set_cfg(2'b10, 16'sd10, -16'sd4, 16'sd1, 8'd1, 5'd4, 8'sd0);
    d = rand_beat();
    d[0 +: WI] = 8'hFD;
    send(d, 1'b1);
    wait_idle();
    chk("gelu_m3_shift4", DW'(last_out[0 +: WI]), DW'(8'hFF));

    set_cfg(2'b10, 16'sd10, -16'sd4, 16'sd1, 8'd1, 5'd4, 8'sd5);
    send(d, 1'b1);
    wait_idle();
    chk("gelu_m3_shift4_add5", DW'(last_out[0 +: WI]), DW'(8'd4));

    // Backpressure: 10 distinct beats, output stalled for five cycles
    set_cfg(2'b10, 16'sd10, -16'sd4, 16'sd1, 8'd1, 5'd0, 8'sd0);
    base_stall = stall_seen;
    base_pop = n_pop;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          d = rand_beat();
          d[WI-1:0] = WI'(i);
          send(d, 1'b0);
        end
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_in_ready_dropped", DW'(stall_seen > base_stall), DW'(1'b1));
    chk("bp_beat_count", DW'(n_pop - base_pop), DW'(10));

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_beat() | DW'(1), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", DW'(out_valid), DW'(1'b0));
    chk("rst_mid_data_o", data_o, '0);
    chk("rst_mid_busy", DW'(busy), DW'(1'b0));
    @(posedge clk);
    #1 out_ready = 1'b1;
    d = rand_beat();
    d[WI-1:0] = 8'd2;
    send(d, 1'b1);
    wait_idle();
    chk("rst_fresh_gelu_2", DW'(last_out[WI-1:0]), DW'(8'd30));

    // Randomized traffic and configuration
    for (int r = 0; r < 8; r++) begin
      out_ready = 1'b1;
      set_cfg(2'(r % 4),
              CW'(int'($urandom_range(0, 400)) - 200),
              (r >= 6) ? CW'(-int'($urandom_range(0, 32768))) : CW'(-int'($urandom_range(0, 60))),
              CW'(int'($urandom_range(0, 2000)) - 1000),
              EMS'($urandom), 5'($urandom_range(0, 14)), WI'($urandom));
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 25; i++) begin
            send(rand_beat(), 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      out_ready = 1'b1;
      wait_idle();
    end

    chk("final_pending", DW'(q.size()), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
